// File: rtl/adder_pipe.sv
// Pipelined WIDTH-bit ripple-carry adder/subtractor, STAGES carry segments, valid/ready stream.
// Define ADDER_PIPE_OVF_EN to build the signed-overflow output; otherwise ovf is tied to 0.
module adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int SEG = WIDTH / STAGES;
    localparam int SW  = SEG + 1;

    logic              stall;
    logic              adv;
    logic [WIDTH-1:0]  b_eff;
    logic [STAGES:0]   vld_pipe;

    assign stall       = out_valid && !out_ready;
    assign in_ready    = !stall;
    assign adv         = !stall;
    assign b_eff       = sub ? ~b : b;
    assign vld_pipe[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO  = k * SEG;
        localparam int REM = WIDTH - LO;

        logic             c_in;
        logic [WIDTH-1:0] r_in;
        logic [REM-1:0]   b_in;
        logic [SW-1:0]    seg_sum;
        logic [WIDTH-1:0] r_d;
        logic             vld_q;
        logic             cy_q;
        // Low bits carry finished sum slices, high bits the not-yet-consumed slices of a.
        logic [WIDTH-1:0] r_q;

        if (k == 0) begin : g_src
            assign c_in = sub | cin;
            assign r_in = a;
            assign b_in = b_eff;
        end else begin : g_src
            assign c_in = g_st[k-1].cy_q;
            assign r_in = g_st[k-1].r_q;
            assign b_in = g_st[k-1].g_fwd.b_q;
        end

        assign seg_sum = {1'b0, r_in[LO +: SEG]} + {1'b0, b_in[SEG-1:0]} + SW'(c_in);

        always_comb begin
            r_d            = r_in;
            r_d[LO +: SEG] = seg_sum[SEG-1:0];
        end

        // Data registers load only with a valid beat so bubbles never pull X inward.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                cy_q  <= 1'b0;
                r_q   <= '0;
            end else if (adv) begin
                vld_q <= vld_pipe[k];
                if (vld_pipe[k]) begin
                    cy_q <= seg_sum[SEG];
                    r_q  <= r_d;
                end
            end
        end

        assign vld_pipe[k+1] = vld_q;

        if (k < STAGES - 1) begin : g_fwd
            logic [REM-SEG-1:0] b_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst)                     b_q <= '0;
                else if (adv && vld_pipe[k]) b_q <= b_in[REM-1:SEG];
            end
        end

`ifdef ADDER_PIPE_OVF_EN
        // The operand MSBs are still unconsumed at the last stage, so ovf lines up with sum.
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (adv && vld_pipe[k]) begin
                    ovf_q <= (r_in[WIDTH-1] == b_in[REM-1]) && (seg_sum[SEG-1] != r_in[WIDTH-1]);
                end
            end
        end
`endif
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = g_st[STAGES-1].r_q;
    assign c_out     = g_st[STAGES-1].cy_q;
`ifdef ADDER_PIPE_OVF_EN
    assign ovf       = g_st[STAGES-1].g_ovf.ovf_q;
`else
    assign ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// Scoreboard bench for adder_pipe: directed vectors push expected beats, a negedge monitor pops them.
// Override WIDTH/STAGES (32/4, 32/1, 8/8) to repeat the suite on other geometries.
module tb_adder_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
);
`ifdef ADDER_PIPE_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic [31:0] va, vb, input logic vc, vs,
                                 input logic [31:0] es, input logic ec, eo);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs; v.s = es; v.c = ec; v.o = eo;
        return v;
    endfunction

    // Hand-computed vectors: carry ripple, borrow, signed overflow both ways, cancellation.
    function automatic vec_t tv(input int i);
        vec_t v;
        v = '0;
        if (WIDTH == 8) begin
            case (i)
                0: v = mkv(32'hFF, 32'h00, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
                1: v = mkv(32'h05, 32'h07, 1'b1, 1'b1, 32'hFE, 1'b0, 1'b0);
                2: v = mkv(32'h7F, 32'h01, 1'b0, 1'b0, 32'h80, 1'b0, 1'b1);
                3: v = mkv(32'h80, 32'h01, 1'b0, 1'b1, 32'h7F, 1'b1, 1'b1);
                4: v = mkv(32'h12, 32'h11, 1'b0, 1'b0, 32'h23, 1'b0, 1'b0);
                5: v = mkv(32'hA5, 32'h5A, 1'b1, 1'b0, 32'h00, 1'b1, 1'b0);
                6: v = mkv(32'h34, 32'h34, 1'b0, 1'b1, 32'h00, 1'b1, 1'b0);
                7: v = mkv(32'h00, 32'h01, 1'b0, 1'b1, 32'hFF, 1'b0, 1'b0);
                default: v = mkv(32'h80, 32'h80, 1'b0, 1'b0, 32'h00, 1'b1, 1'b1);
            endcase
        end else begin
            case (i)
                0: v = mkv(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
                1: v = mkv(32'h5, 32'h7, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
                2: v = mkv(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
                3: v = mkv(32'h80000000, 32'h1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
                4: v = mkv(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);
                5: v = mkv(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0);
                6: v = mkv(32'h1234, 32'h1234, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
                7: v = mkv(32'h0, 32'h1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
                default: v = mkv(32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1);
            endcase
        end
        return v;
    endfunction

    function automatic exp_t mke(input logic [WIDTH-1:0] s, input logic c, o);
        exp_t e;
        e.s = s; e.c = c; e.o = o & OVF_EN;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Called at posedge+#1; returns at the posedge+#1 after the beat was accepted.
    task automatic send(input logic [WIDTH-1:0] va, vb, input logic vc, vs, input exp_t e);
        int g;
        g = 0;
        in_valid = 1'b1; a = va; b = vb; cin = vc; sub = vs;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            g++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        out_ready = 1'b1;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk); #1;
            g++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (STAGES + 2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("no_x_out", 64'($isunknown({out_valid, sum, c_out, ovf})), 64'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", sum);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sum", 64'(sum), 64'(e.s));
                    chk("c_out", 64'(c_out), 64'(e.c));
                    chk("ovf", 64'(ovf), 64'(e.o));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   n;
        int   stale;
        logic hist [0:63];

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_c_out", 64'(c_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency of a lone beat (full carry ripple).
        v = tv(0);
        in_valid = 1'b1; a = WIDTH'(v.a); b = WIDTH'(v.b); cin = v.cin; sub = v.sub;
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        exp_q.push_back(mke(WIDTH'(v.s), v.c, v.o));
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(STAGES));
        drain();

        for (int i = 1; i < 9; i++) begin
            v = tv(i);
            send(WIDTH'(v.a), WIDTH'(v.b), v.cin, v.sub, mke(WIDTH'(v.s), v.c, v.o));
        end
        drain();

        // Backpressure: 3-cycle stall on the first result of a back-to-back stream.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(WIDTH'(i), WIDTH'(i), 1'b0, 1'b0, mke(WIDTH'(2 * i), 1'b0, 1'b0));
            end
            begin
                int g;
                g = 0;
                while (!out_valid && g < 100) begin
                    @(posedge clk); #1;
                    g++;
                end
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready", 64'(in_ready), 64'd0);
                    chk("bp_held_valid", 64'(out_valid), 64'd1);
                    chk("bp_held_sum", 64'(sum), 64'd0);
                    chk("bp_held_c_out", 64'(c_out), 64'd0);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Bubbles: alternate valid, out_valid must mirror the pattern STAGES cycles later.
        for (int t = 0; t < 8 + STAGES + 1; t++) begin
            in_valid = (t < 8) && (t % 2 == 0);
            a = WIDTH'(t); b = WIDTH'(3); cin = 1'b0; sub = 1'b0;
            hist[t] = in_valid;
            if (in_valid) exp_q.push_back(mke(WIDTH'(t + 3), 1'b0, 1'b0));
            @(negedge clk);
            chk("bubble_in_ready", 64'(in_ready), 64'd1);
            if (t >= STAGES) chk("bubble_pattern", 64'(out_valid), 64'(hist[t - STAGES]));
            else             chk("bubble_empty", 64'(out_valid), 64'd0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain();

        // Reset with the pipeline full and stalled; nothing may emerge afterwards.
        out_ready = 1'b0;
        for (int t = 0; t < STAGES + 2; t++) begin
            in_valid = 1'b1; a = WIDTH'(t + 1); b = WIDTH'(t + 1); cin = 1'b0; sub = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum", 64'(sum), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        repeat (2 * STAGES + 4) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("no_stale", 64'(stale), 64'd0);
        @(posedge clk); #1;

        v = tv(2);
        send(WIDTH'(v.a), WIDTH'(v.b), v.cin, v.sub, mke(WIDTH'(v.s), v.c, v.o));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Parametrised, pipelined ripple-carry adder/subtractor with a valid/ready stream interface. It generalises the fixed 8-bit full-adder chain to WIDTH bits split into STAGES registered carry segments, adds a subtract mode, and adds a signed-overflow flag. One operation enters per cycle and results leave in order. It sits in the datapath wherever a long carry chain would otherwise limit clock frequency.

## Interface
- WIDTH, 32: operand and result width in bits. Must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages. Each stage adds a slice of SEG = WIDTH/STAGES bits. Legal range 1..WIDTH.
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  the operand beat is valid.
- in_ready  output  1  the pipeline accepts a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry in. Used only when sub=0.
- sub  input  1  mode select: 0 = a+b+cin, 1 = a-b.
- out_valid  output  1  the result beat is valid.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of the MSB. In subtract mode this is the inverted borrow (1 = no borrow).
- ovf  output  1  two's-complement signed overflow. See Configuration.

## Operation
- Add: result = a + b + cin.
- Subtract: result = a + ~b + 1. The cin input is ignored.
- Stage k (0..STAGES-1) computes bits [k·SEG +: SEG] from the carry registered by stage k-1. Stage 0 uses the input carry.
- Operand slices not yet consumed travel with the beat in pipeline registers. Sum slices already produced are delayed so that all of sum appears aligned at the output.
- Each stage holds a valid bit. The pipeline behaves as a shift register of beats, including bubbles.
- stall = out_valid && !out_ready.
  - When stall=0, every stage advances.
  - When stall=1, every stage holds.
- in_ready = !stall.
- A beat is accepted when in_valid && in_ready. An invalid input cycle inserts a bubble; bubbles are not collapsed.
- A beat is transferred out when out_valid && out_ready.
- sum, c_out and ovf must stay stable while out_valid=1 and out_ready=0.
- sum, c_out and ovf are don't-care when out_valid=0. The implementation must not generate X on them.
- There is no state machine beyond the per-stage valid bits.

## Timing
- Latency: a beat accepted at rising edge N is presented with out_valid=1 after edge N+STAGES, provided no stall occurs in between.
- Throughput: 1 beat per cycle while out_ready=1.
- Each cycle of stall adds one cycle of latency to every beat in flight.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from a, b or in_valid to any output.
- Reset values: out_valid=0, sum=0, c_out=0, ovf=0, and all stage valid bits 0.
  - in_ready therefore reads 1 during reset and from the first cycle after reset.
- Reset asserted mid-stream discards all beats in flight immediately, asynchronously. No partial result is emitted after reset releases.
- STAGES=1: a single registered adder with latency 1.
- Wrap-around: results are truncated to WIDTH bits. The carry beyond the MSB appears only on c_out.

## Configuration
- Macro ADDER_PIPE_OVF_EN.
- Defined:
  - ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' = ~b in subtract mode.
  - The operand MSBs are carried down the pipeline so that ovf is aligned with sum.
- Undefined:
  - The overflow logic and its MSB pipeline registers are not built.
  - ovf is tied to 0. The port remains present.

## Test plan
All scenarios use WIDTH=32 and STAGES=4 unless noted.

- Carry across all segments:
  - Stimulus: a=0xFFFFFFFF, b=0, cin=1, sub=0, out_ready=1.
  - Required: after 4 edges, sum=0x00000000, c_out=1, ovf=0.
- Subtract with borrow:
  - Stimulus: a=5, b=7, sub=1, cin=1.
  - Required: sum=0xFFFFFFFE, c_out=0, ovf=0. This also confirms cin is ignored.
- Signed overflow, ADDER_PIPE_OVF_EN defined:
  - Stimulus: a=0x7FFFFFFF, b=1, sub=0, cin=0.
  - Required: sum=0x80000000, ovf=1.
  - Then a=0x80000000, b=1, sub=1 gives sum=0x7FFFFFFF, ovf=1.
  - With the macro undefined, ovf=0 for both.
- Backpressure:
  - Stimulus: stream a=i, b=i, cin=0 for i=0..7 back-to-back; hold out_ready=0 for 3 cycles after the first result appears.
  - Required: in_ready=0 during those 3 cycles. Outputs 0,2,4,…,14 arrive in order with no loss or duplication, and the held result stays stable.
- Bubbles:
  - Stimulus: in_valid alternates 1/0.
  - Required: out_valid alternates with the same pattern, delayed 4 cycles.
- Reset mid-operation:
  - Stimulus: assert rst with 3 beats in flight.
  - Required: out_valid=0 immediately, and no stale beats appear after rst releases.
  - Repeat the whole suite with STAGES=1 and WIDTH=8, STAGES=8.
